jt12_lfo_cfg_seq: RTL and testbench
===================================

// Module: jt12_lfo_cfg_seq
// PURPOSE
//  Sequencer/configurator for the LFO counter block. Captures CPU writes to LFO register 0x22
//  (bit3 = enable, bits2:0 = rate), and commits them to the LFO only on a sample boundary
//  (zero strobe). Generates a clean one-cycle lfo_rst on every off->on enable transition.
//  Post-processes the LFO's 7-bit phase into registered AM (triangle) and PM (signed step) words
//  for the operator pipeline. Sits between the register file and the LFO counter.
// PARAMETERS
//  LFO_ADDR   8'h22  register address decoded as the LFO control register
// PORTS
//  rst        in   1  synchronous reset, active-high
//  clk        in   1  clock
//  zero       in   1  sample-boundary strobe, one cycle wide
//  wr         in   1  CPU write strobe, one cycle wide
//  addr       in   8  CPU register address, valid with wr
//  din        in   8  CPU write data, valid with wr
//  busy       out  1  a captured LFO write is waiting for commit
//  lfo_en     out  1  committed enable, to the LFO block
//  lfo_freq   out  3  committed rate select, to the LFO block
//  lfo_rst    out  1  one-cycle LFO counter clear, to the LFO block
//  lfo_mod    in   7  LFO phase, from the LFO block
//  am_out     out  7  AM level: triangle folded from lfo_mod
//  pm_out     out  5  PM step: signed, from lfo_mod[6:2]
// BEHAVIOUR
//  Reset values: busy=0, lfo_en=0, lfo_freq=0, lfo_rst=0, am_out=0, pm_out=0, FSM=IDLE,
//    pending register=0.
//  Decode: a write is accepted only when wr=1 and addr==LFO_ADDR. din[7:4] is ignored.
//    Writes to any other address have no effect.
//  FSM states:
//    IDLE: on an accepted write, latch pend={din[3],din[2:0]} and go to PEND; busy=1 from the
//      next cycle.
//    PEND: further accepted writes overwrite pend (last write wins, no queue). When zero=1,
//      commit pend to lfo_en/lfo_freq in the same cycle, then go to IDLE and drop busy.
//    Same-cycle write+commit: if an accepted write and zero arrive together in PEND, commit the
//      old pend. Then re-latch the new data and stay in PEND; busy remains 1.
//    Write in IDLE with zero=1 in the same cycle: latch only. Commit happens at the next zero,
//      never the same cycle.
//  lfo_rst: asserted for exactly one cycle, the cycle after a commit that takes lfo_en 0->1.
//    A commit with en 1->1 (rate change only) does not pulse; the counter keeps its phase.
//    A commit with en 1->0 does not pulse; the LFO clears itself while disabled.
//  Commit latency: the new config is visible on lfo_en/lfo_freq one cycle after the zero strobe
//    (registered outputs).
//  AM/PM: registered, updated only on cycles with zero=1; held between strobes. Latency is one
//    cycle after the zero strobe.
//    am_out = lfo_mod[6] ? ~lfo_mod[5:0],1'b0 : lfo_mod[5:0],1'b0  (0..126 triangle).
//    pm_out = {lfo_mod[6], lfo_mod[6] ? ~lfo_mod[5:2] : lfo_mod[5:2]}  (sign-magnitude).
//    When committed lfo_en==0, am_out and pm_out are forced to 0 at the next zero.
//  Reset mid-operation: discards pend and the committed config; all outputs return to their
//    reset values the next cycle.
// STRUCTURE
//  Shared package jt12_pkg:
//    LFO_ADDR default.
//    FSM state encoding typedef {IDLE, PEND}.
//    Widths LFO_W=7, PM_W=5.
//  One sub-module: jt12_lfo_shape. Contains the registered AM/PM folding with zero/enable
//    gating. The config FSM and lfo_rst generation stay in the top module.
// TESTING
//  1 Reset then idle 100 cycles -> all outputs 0, busy=0, no lfo_rst.
//  2 wr addr=22 din=0x0B, zero 10 cycles later -> busy=1 for those cycles; then lfo_en=1,
//    lfo_freq=3 one cycle after zero; lfo_rst pulses once.
//  3 Enabled with freq=3; write 0x0E, then zero -> lfo_freq=6, lfo_en stays 1, no lfo_rst.
//  4 Writes 0x09 then 0x0F before zero -> commit is freq=7 only. Write addr=0x28 din=0x0F
//    -> ignored, busy unchanged.
//  5 In PEND, write 0x0A in the same cycle as zero -> old pend committed, busy stays 1.
//    0x0A commits at the next zero.
//  6 lfo_mod=0x45, zero -> am_out=0x74, pm_out=5'h1E.
//    Then commit en=0, next zero -> am_out=0, pm_out=0.
//    Assert rst while in PEND -> busy=0 and the pending write is never committed.

Source files
------------

// File: rtl/jt12_pkg.sv
// Shared definitions for the JT12 LFO configuration sequencer: register address,
// widths, FSM encoding and the phase-folding helpers used by the shaper.
package jt12_pkg;

  localparam logic [7:0] LFO_ADDR_DEFAULT = 8'h22;
  localparam int LFO_W = 7;
  localparam int PM_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cfg_state_t;

  // The upper phase bit selects the falling half of the triangle.
  function automatic logic [LFO_W-1:0] am_fold(input logic [LFO_W-1:0] mod);
    return mod[6] ? {~mod[5:0], 1'b0} : {mod[5:0], 1'b0};
  endfunction

  function automatic logic [PM_W-1:0] pm_fold(input logic [LFO_W-1:0] mod);
    return {mod[6], mod[6] ? ~mod[5:2] : mod[5:2]};
  endfunction

endpackage

// File: rtl/jt12_lfo_cfg_seq_if.sv
// CPU register-write bus feeding the LFO configuration sequencer.
interface jt12_lfo_cfg_seq_if;

  logic       wr;
  logic [7:0] addr;
  logic [7:0] din;

  modport master (output wr, output addr, output din);
  modport slave  (input  wr, input  addr, input  din);

endinterface

// File: rtl/jt12_lfo_shape.sv
// Registered AM/PM post-processing of the LFO phase, refreshed only on sample boundaries.
module jt12_lfo_shape
  import jt12_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             zero,
  input  logic             lfo_en,
  input  logic [LFO_W-1:0] lfo_mod,
  output logic [LFO_W-1:0] am_out,
  output logic [PM_W-1:0]  pm_out
);

  // A disabled LFO must not leave a stale modulation level on the operators.
  always_ff @(posedge clk) begin
    if (rst) begin
      am_out <= '0;
      pm_out <= '0;
    end else if (zero) begin
      if (lfo_en) begin
        am_out <= am_fold(lfo_mod);
        pm_out <= pm_fold(lfo_mod);
      end else begin
        am_out <= '0;
        pm_out <= '0;
      end
    end
  end

endmodule

// File: rtl/jt12_lfo_cfg_seq.sv
// LFO register capture, sample-aligned commit and counter-clear generation,
// plus AM/PM shaping of the LFO phase.
module jt12_lfo_cfg_seq
  import jt12_pkg::*;
#(
  parameter logic [7:0] LFO_ADDR = LFO_ADDR_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    zero,
  jt12_lfo_cfg_seq_if.slave       cpu,
  output logic                    busy,
  output logic                    lfo_en,
  output logic [2:0]              lfo_freq,
  output logic                    lfo_rst,
  input  logic [LFO_W-1:0]        lfo_mod,
  output logic [LFO_W-1:0]        am_out,
  output logic [PM_W-1:0]         pm_out
);

  cfg_state_t state;
  logic [3:0] pend;
  logic       wr_ok;
  logic       unused_din_hi;

  assign wr_ok         = cpu.wr && (cpu.addr == LFO_ADDR);
  assign unused_din_hi = &{1'b0, cpu.din[7:4]};

  // A write arriving together with the commit strobe re-arms PEND after the old value lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      busy     <= 1'b0;
      lfo_en   <= 1'b0;
      lfo_freq <= '0;
      lfo_rst  <= 1'b0;
    end else begin
      lfo_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ok) begin
            pend  <= cpu.din[3:0];
            state <= PEND;
            busy  <= 1'b1;
          end
        end
        PEND: begin
          if (zero) begin
            lfo_en   <= pend[3];
            lfo_freq <= pend[2:0];
            lfo_rst  <= pend[3] & ~lfo_en;
            if (wr_ok) begin
              pend <= cpu.din[3:0];
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (wr_ok) begin
            pend <= cpu.din[3:0];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  jt12_lfo_shape u_shape (
    .clk     (clk),
    .rst     (rst),
    .zero    (zero),
    .lfo_en  (lfo_en),
    .lfo_mod (lfo_mod),
    .am_out  (am_out),
    .pm_out  (pm_out)
  );

endmodule

// File: tb/tb_jt12_lfo_cfg_seq.sv
// Directed, table-driven bench for the LFO configuration sequencer.
module tb_jt12_lfo_cfg_seq;

  logic       clk;
  logic       rst;
  logic       zero;
  logic       busy;
  logic       lfo_en;
  logic [2:0] lfo_freq;
  logic       lfo_rst;
  logic [6:0] lfo_mod;
  logic [6:0] am_out;
  logic [4:0] pm_out;

  int checks_total;
  int checks_passed;

  jt12_lfo_cfg_seq_if cpu ();

  jt12_lfo_cfg_seq dut (
    .clk      (clk),
    .rst      (rst),
    .zero     (zero),
    .cpu      (cpu),
    .busy     (busy),
    .lfo_en   (lfo_en),
    .lfo_freq (lfo_freq),
    .lfo_rst  (lfo_rst),
    .lfo_mod  (lfo_mod),
    .am_out   (am_out),
    .pm_out   (pm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
    logic       zero;
    logic [6:0] mod;
    logic       busy;
    logic       en;
    logic [2:0] freq;
    logic       rst;
    logic [6:0] am;
    logic [4:0] pm;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic wr, input logic [7:0] addr, input logic [7:0] din,
                         input logic z, input logic [6:0] mod, input logic b, input logic en,
                         input logic [2:0] freq, input logic r, input logic [6:0] am,
                         input logic [4:0] pm);
    vec_t v;
    v.wr = wr; v.addr = addr; v.din = din; v.zero = z; v.mod = mod;
    v.busy = b; v.en = en; v.freq = freq; v.rst = r; v.am = am; v.pm = pm;
    vecs.push_back(v);
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic apply_stimulus(input logic wr, input logic [7:0] addr, input logic [7:0] din,
                                input logic z, input logic [6:0] mod);
    cpu.wr   = wr;
    cpu.addr = addr;
    cpu.din  = din;
    zero     = z;
    lfo_mod  = mod;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic b, input logic en,
                              input logic [2:0] freq, input logic r, input logic [6:0] am,
                              input logic [4:0] pm);
    logic [17:0] act;
    logic [17:0] exp;
    act = {busy, lfo_en, lfo_freq, lfo_rst, am_out, pm_out};
    exp = {b, en, freq, r, am, pm};
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got busy=%b en=%b freq=%0d rst=%b am=%h pm=%h, expected busy=%b en=%b freq=%0d rst=%b am=%h pm=%h",
               name, busy, lfo_en, lfo_freq, lfo_rst, am_out, pm_out, b, en, freq, r, am, pm);
    end
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst      = 1'b1;
    cpu.wr   = 1'b0;
    cpu.addr = 8'h00;
    cpu.din  = 8'h00;
    zero     = 1'b0;
    lfo_mod  = 7'h00;

    // Sequence rows: wr addr din zero mod | busy en freq rst am pm (state after the edge)
    add_vec(1, 8'h22, 8'h0E, 0, 7'h00, 1, 1, 3'd3, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 1, 7'h00, 0, 1, 3'd6, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 0, 7'h00, 0, 1, 3'd6, 0, 7'h00, 5'h00);
    add_vec(1, 8'h22, 8'h09, 0, 7'h00, 1, 1, 3'd6, 0, 7'h00, 5'h00);
    add_vec(1, 8'h22, 8'h0F, 0, 7'h00, 1, 1, 3'd6, 0, 7'h00, 5'h00);
    add_vec(1, 8'h28, 8'h0F, 0, 7'h00, 1, 1, 3'd6, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 1, 7'h00, 0, 1, 3'd7, 0, 7'h00, 5'h00);
    add_vec(1, 8'h28, 8'h0F, 0, 7'h00, 0, 1, 3'd7, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 0, 7'h00, 0, 1, 3'd7, 0, 7'h00, 5'h00);
    add_vec(1, 8'h22, 8'h0C, 0, 7'h00, 1, 1, 3'd7, 0, 7'h00, 5'h00);
    add_vec(1, 8'h22, 8'h0A, 1, 7'h00, 1, 1, 3'd4, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 0, 7'h00, 1, 1, 3'd4, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 1, 7'h00, 0, 1, 3'd2, 0, 7'h00, 5'h00);
    add_vec(1, 8'h22, 8'h0D, 1, 7'h00, 1, 1, 3'd2, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 0, 7'h00, 1, 1, 3'd2, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 1, 7'h00, 0, 1, 3'd5, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 1, 7'h45, 0, 1, 3'd5, 0, 7'h74, 5'h1E);
    add_vec(0, 8'h00, 8'h00, 0, 7'h00, 0, 1, 3'd5, 0, 7'h74, 5'h1E);
    add_vec(1, 8'h22, 8'h05, 0, 7'h45, 1, 1, 3'd5, 0, 7'h74, 5'h1E);
    add_vec(0, 8'h00, 8'h00, 1, 7'h45, 0, 0, 3'd5, 0, 7'h74, 5'h1E);
    add_vec(0, 8'h00, 8'h00, 1, 7'h45, 0, 0, 3'd5, 0, 7'h00, 5'h00);
    add_vec(1, 8'h22, 8'h08, 0, 7'h45, 1, 0, 3'd5, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 1, 7'h45, 0, 1, 3'd0, 1, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 0, 7'h45, 0, 1, 3'd0, 0, 7'h00, 5'h00);
    add_vec(0, 8'h00, 8'h00, 1, 7'h12, 0, 1, 3'd0, 0, 7'h24, 5'h04);
    add_vec(0, 8'h00, 8'h00, 1, 7'h7F, 0, 1, 3'd0, 0, 7'h00, 5'h10);
    add_vec(0, 8'h00, 8'h00, 1, 7'h40, 0, 1, 3'd0, 0, 7'h7E, 5'h1F);

    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 0, 0, 3'd0, 0, 7'h00, 5'h00);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      apply_stimulus(0, 8'h00, 8'h00, 0, 7'h00);
      check_output($sformatf("idle%0d", i), 0, 0, 3'd0, 0, 7'h00, 5'h00);
    end

    // First enable: busy through the wait, then commit with a single counter clear.
    apply_stimulus(1, 8'h22, 8'h0B, 0, 7'h00);
    check_output("en_wr", 1, 0, 3'd0, 0, 7'h00, 5'h00);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(0, 8'h00, 8'h00, 0, 7'h00);
      check_output($sformatf("en_wait%0d", i), 1, 0, 3'd0, 0, 7'h00, 5'h00);
    end
    apply_stimulus(0, 8'h00, 8'h00, 1, 7'h00);
    check_output("en_commit", 0, 1, 3'd3, 1, 7'h00, 5'h00);
    apply_stimulus(0, 8'h00, 8'h00, 0, 7'h00);
    check_output("en_rst_drop", 0, 1, 3'd3, 0, 7'h00, 5'h00);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].zero, vecs[i].mod);
      check_output($sformatf("vec%0d", i), vecs[i].busy, vecs[i].en, vecs[i].freq,
                   vecs[i].rst, vecs[i].am, vecs[i].pm);
    end

    // Reset while a write is pending must drop it entirely.
    apply_stimulus(1, 8'h22, 8'h0B, 0, 7'h40);
    check_output("pend_setup", 1, 1, 3'd0, 0, 7'h7E, 5'h1F);
    rst = 1'b1;
    apply_stimulus(0, 8'h00, 8'h00, 1, 7'h45);
    check_output("mid_reset", 0, 0, 3'd0, 0, 7'h00, 5'h00);
    rst = 1'b0;
    apply_stimulus(0, 8'h00, 8'h00, 1, 7'h45);
    check_output("post_reset_zero", 0, 0, 3'd0, 0, 7'h00, 5'h00);
    apply_stimulus(0, 8'h00, 8'h00, 0, 7'h45);
    check_output("post_reset_idle", 0, 0, 3'd0, 0, 7'h00, 5'h00);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
